cpu_run_ctrl: RTL and testbench

- Synthesizable run controller for the lab CPU.
- Streams a program image into instruction memory, then drives the CPU's active-low reset for a fixed number of cycles and releases it.
- Counts execution cycles and stops on a CPU halt or on a cycle-budget timeout.
- Latches the CPU's observed result word and a status summary, replacing the ad-hoc load/reset/run/finish sequencing done by hand in simulation.

---
 rtl/cpu_run_ctrl.sv | 233 +++++++++++++++++++++++
 tb/tb_cpu_run_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_run_ctrl.sv
// -----------------------------------------------------------------------------
// cpu_run_ctrl
//
// Run controller for the lab CPU. One start pulse performs a full sequence:
//   1. LOAD  : accept a program image over a valid/ready stream and write it
//              into instruction memory, one word per accepted beat.
//   2. RESET : hold the CPU's active-low reset for RST_CYCLES cycles.
//   3. RUN   : release the CPU and count cycles until it halts or the cycle
//              budget MAX_CYCLES is used up.
//   4. DONE  : put the CPU back into reset (freezing it) and hold the status
//              (result word, cycle count, timeout and truncation flags).
//
// Ports
//   clk           in   system clock, rising edge
//   rst           in   synchronous active-high reset
//   start         in   single-cycle pulse, honoured in IDLE or DONE only
//   load_valid    in   program word available
//   load_ready    out  word accepted this cycle (combinational)
//   load_data     in   program word
//   load_last     in   final word of the image
//   im_we         out  instruction-memory write enable (combinational)
//   im_addr       out  instruction-memory write address (combinational)
//   im_wdata      out  instruction-memory write data (combinational)
//   cpu_rst_n     out  active-low CPU reset (registered)
//   cpu_halt      in   CPU halt indication, looked at in RUN only
//   cpu_data      in   CPU result bus, captured when RUN ends
//   busy          out  sequence in progress (LOAD, RESET, RUN)
//   done          out  sequence finished (DONE)
//   timeout       out  RUN ended on the cycle budget
//   load_trunc    out  memory filled before load_last was seen
//   words_loaded  out  number of words written (ADDR_W+1 bits)
//   cycle_count   out  number of RUN cycles executed
//   result        out  cpu_data captured on the RUN exit cycle
// -----------------------------------------------------------------------------
module cpu_run_ctrl #(
   parameter int unsigned ADDR_W     = 8,
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned RST_CYCLES = 2,
   parameter int unsigned MAX_CYCLES = 50,
   parameter int unsigned CNT_W      = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              load_valid,
   output logic              load_ready,
   input  logic [DATA_W-1:0] load_data,
   input  logic              load_last,
   output logic              im_we,
   output logic [ADDR_W-1:0] im_addr,
   output logic [DATA_W-1:0] im_wdata,
   output logic              cpu_rst_n,
   input  logic              cpu_halt,
   input  logic [DATA_W-1:0] cpu_data,
   output logic              busy,
   output logic              done,
   output logic              timeout,
   output logic              load_trunc,
   output logic [ADDR_W:0]   words_loaded,
   output logic [CNT_W-1:0]  cycle_count,
   output logic [DATA_W-1:0] result
);

   // --------------------------------------------------------------------------
   // State encoding
   // --------------------------------------------------------------------------
   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_LOAD  = 3'd1;
   localparam logic [2:0] ST_RESET = 3'd2;
   localparam logic [2:0] ST_RUN   = 3'd3;
   localparam logic [2:0] ST_DONE  = 3'd4;

   // The reset-hold counter only has to reach RST_CYCLES-1.
   localparam int unsigned RCNT_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

   localparam logic [RCNT_W-1:0] RCNT_LAST  = RCNT_W'(RST_CYCLES - 1);
   localparam logic [CNT_W-1:0]  CYC_BUDGET = CNT_W'(MAX_CYCLES);
   localparam logic [ADDR_W-1:0] ADDR_TOP   = '1;

   // --------------------------------------------------------------------------
   // Registers
   // --------------------------------------------------------------------------
   logic [2:0]        state_q,     state_d;
   logic [ADDR_W:0]   words_q,     words_d;
   logic [CNT_W-1:0]  cyc_q,       cyc_d;
   logic [RCNT_W-1:0] rcnt_q,      rcnt_d;
   logic              timeout_q,   timeout_d;
   logic              trunc_q,     trunc_d;
   logic [DATA_W-1:0] result_q,    result_d;
   logic              cpu_rst_n_q, cpu_rst_n_d;
   logic              busy_q,      busy_d;
   logic              done_q,      done_d;

   // A word moves only in LOAD; rst suppresses the handshake so no write is
   // issued in the cycle that reset is applied.
   logic xfer;

   // --------------------------------------------------------------------------
   // Load handshake and memory write port (combinational)
   // --------------------------------------------------------------------------
   always_comb begin
      load_ready = (state_q == ST_LOAD) && !rst;
      xfer       = load_ready && load_valid;
      im_we      = xfer;
      im_addr    = words_q[ADDR_W-1:0];
      im_wdata   = load_data;
   end

   // --------------------------------------------------------------------------
   // Next-state logic
   // --------------------------------------------------------------------------
   always_comb begin
      state_d   = state_q;
      words_d   = words_q;
      cyc_d     = cyc_q;
      rcnt_d    = rcnt_q;
      timeout_d = timeout_q;
      trunc_d   = trunc_q;
      result_d  = result_q;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            // Starting a new sequence clears the run status; the previous
            // result stays visible until the next run overwrites it.
            if (start) begin
               state_d   = ST_LOAD;
               words_d   = '0;
               cyc_d     = '0;
               timeout_d = 1'b0;
               trunc_d   = 1'b0;
            end
         end

         ST_LOAD: begin
            if (xfer) begin
               words_d = words_q + (ADDR_W+1)'(1);
               if (load_last) begin
                  state_d = ST_RESET;
                  rcnt_d  = '0;
               end else if (words_q[ADDR_W-1:0] == ADDR_TOP) begin
                  // Last memory slot written without load_last: stop
                  // accepting and flag the image as truncated.
                  state_d = ST_RESET;
                  rcnt_d  = '0;
                  trunc_d = 1'b1;
               end
            end
         end

         ST_RESET: begin
            if (rcnt_q == RCNT_LAST) begin
               state_d = ST_RUN;
            end else begin
               rcnt_d = rcnt_q + RCNT_W'(1);
            end
         end

         ST_RUN: begin
            // The exiting cycle is counted too, so a halt on the Nth RUN
            // cycle reports N. Halt is tested first so it wins over budget.
            cyc_d = cyc_q + CNT_W'(1);
            if (cpu_halt) begin
               state_d   = ST_DONE;
               timeout_d = 1'b0;
               result_d  = cpu_data;
            end else if (cyc_d == CYC_BUDGET) begin
               state_d   = ST_DONE;
               timeout_d = 1'b1;
               result_d  = cpu_data;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // --------------------------------------------------------------------------
   // Registered status outputs, decoded from the next state so they line up
   // with state_q after the edge.
   // --------------------------------------------------------------------------
   always_comb begin
      cpu_rst_n_d = (state_d == ST_RUN);
      busy_d      = (state_d == ST_LOAD) || (state_d == ST_RESET) ||
                    (state_d == ST_RUN);
      done_d      = (state_d == ST_DONE);
   end

   // --------------------------------------------------------------------------
   // Sequential state
   // --------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         words_q     <= '0;
         cyc_q       <= '0;
         rcnt_q      <= '0;
         timeout_q   <= 1'b0;
         trunc_q     <= 1'b0;
         result_q    <= '0;
         cpu_rst_n_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         words_q     <= words_d;
         cyc_q       <= cyc_d;
         rcnt_q      <= rcnt_d;
         timeout_q   <= timeout_d;
         trunc_q     <= trunc_d;
         result_q    <= result_d;
         cpu_rst_n_q <= cpu_rst_n_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   // --------------------------------------------------------------------------
   // Output assignments
   // --------------------------------------------------------------------------
   always_comb begin
      cpu_rst_n    = cpu_rst_n_q;
      busy         = busy_q;
      done         = done_q;
      timeout      = timeout_q;
      load_trunc   = trunc_q;
      words_loaded = words_q;
      cycle_count  = cyc_q;
      result       = result_q;
   end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cpu_run_ctrl
//
// Directed bench for cpu_run_ctrl with a 4-word instruction memory
// (ADDR_W=2) so that the full-memory and truncation cases are short.
// Inputs change 1 time unit after the rising edge; outputs are checked there.
// -----------------------------------------------------------------------------
module tb_cpu_run_ctrl;

   localparam int unsigned AW = 2;
   localparam int unsigned DW = 32;
   localparam int unsigned RC = 2;
   localparam int unsigned MC = 50;
   localparam int unsigned CW = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          load_valid;
   logic          load_ready;
   logic [DW-1:0] load_data;
   logic          load_last;
   logic          im_we;
   logic [AW-1:0] im_addr;
   logic [DW-1:0] im_wdata;
   logic          cpu_rst_n;
   logic          cpu_halt;
   logic [DW-1:0] cpu_data;
   logic          busy;
   logic          done;
   logic          timeout;
   logic          load_trunc;
   logic [AW:0]   words_loaded;
   logic [CW-1:0] cycle_count;
   logic [DW-1:0] result;

   int unsigned n_cmp = 0;
   int unsigned n_mis = 0;

   cpu_run_ctrl #(
      .ADDR_W     (AW),
      .DATA_W     (DW),
      .RST_CYCLES (RC),
      .MAX_CYCLES (MC),
      .CNT_W      (CW)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .load_valid   (load_valid),
      .load_ready   (load_ready),
      .load_data    (load_data),
      .load_last    (load_last),
      .im_we        (im_we),
      .im_addr      (im_addr),
      .im_wdata     (im_wdata),
      .cpu_rst_n    (cpu_rst_n),
      .cpu_halt     (cpu_halt),
      .cpu_data     (cpu_data),
      .busy         (busy),
      .done         (done),
      .timeout      (timeout),
      .load_trunc   (load_trunc),
      .words_loaded (words_loaded),
      .cycle_count  (cycle_count),
      .result       (result)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] got,
                            input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Stream n contiguous words; each beat is checked against the address it
   // must land at and the data presented.
   task automatic load_words(input int n, input bit with_last,
                             input logic [31:0] base);
      for (int i = 0; i < n; i++) begin
         load_valid = 1'b1;
         load_data  = base + 32'(i);
         load_last  = with_last && (i == n - 1);
         #1;
         check_val("ld_we",    64'(im_we),    64'd1);
         check_val("ld_addr",  64'(im_addr),  64'(i));
         check_val("ld_wdata", 64'(im_wdata), 64'(base + 32'(i)));
         tick();
      end
      load_valid = 1'b0;
      load_last  = 1'b0;
   endtask

   // Run k = 1..n RUN cycles, raising cpu_halt on cycle halt_at (0 = never).
   task automatic run_cycles(input int n, input int halt_at,
                             input logic [31:0] dbase);
      for (int k = 1; k <= n; k++) begin
         cpu_halt = (k == halt_at);
         cpu_data = dbase + 32'(k);
         tick();
      end
      cpu_halt = 1'b0;
   endtask

   initial begin
      rst        = 1'b1;
      start      = 1'b0;
      load_valid = 1'b0;
      load_last  = 1'b0;
      load_data  = '0;
      cpu_halt   = 1'b0;
      cpu_data   = '0;
      tick();
      tick();
      rst = 1'b0;
      #1;

      // ---- reset state ----
      check_val("rst_cpu_rst_n", 64'(cpu_rst_n),    64'd0);
      check_val("rst_busy",      64'(busy),         64'd0);
      check_val("rst_done",      64'(done),         64'd0);
      check_val("rst_timeout",   64'(timeout),      64'd0);
      check_val("rst_trunc",     64'(load_trunc),   64'd0);
      check_val("rst_words",     64'(words_loaded), 64'd0);
      check_val("rst_cycles",    64'(cycle_count),  64'd0);
      check_val("rst_result",    64'(result),       64'd0);
      check_val("rst_im_we",     64'(im_we),        64'd0);
      check_val("rst_ready",     64'(load_ready),   64'd0);

      // ---- load 4 words (last on 4th, fills memory exactly) and halt ----
      pulse_start();
      check_val("t1_busy",  64'(busy),       64'd1);
      check_val("t1_ready", 64'(load_ready), 64'd1);
      load_words(4, 1'b1, 32'h1000_0000);
      check_val("t1_words",     64'(words_loaded), 64'd4);
      check_val("t1_trunc",     64'(load_trunc),   64'd0);
      check_val("t1_ready_off", 64'(load_ready),   64'd0);
      check_val("t1_crst_r1",   64'(cpu_rst_n),    64'd0);
      tick();
      check_val("t1_crst_r2",   64'(cpu_rst_n),    64'd0);
      tick();
      check_val("t1_crst_run",  64'(cpu_rst_n),    64'd1);
      check_val("t1_cyc_start", 64'(cycle_count),  64'd0);
      run_cycles(4, 0, 32'hA000_0000);
      check_val("t1_cyc_mid",   64'(cycle_count),  64'd4);
      check_val("t1_busy_run",  64'(busy),         64'd1);
      for (int k = 5; k <= 10; k++) begin
         cpu_halt = (k == 10);
         cpu_data = 32'hA000_0000 + 32'(k);
         tick();
      end
      cpu_halt = 1'b0;
      check_val("t1_done",    64'(done),        64'd1);
      check_val("t1_busy",    64'(busy),        64'd0);
      check_val("t1_timeout", 64'(timeout),     64'd0);
      check_val("t1_cycles",  64'(cycle_count), 64'd10);
      check_val("t1_result",  64'(result),      64'hA000_000A);
      check_val("t1_crst",    64'(cpu_rst_n),   64'd0);
      tick();
      tick();
      check_val("t1_hold_done", 64'(done),        64'd1);
      check_val("t1_hold_cyc",  64'(cycle_count), 64'd10);

      // ---- timeout: restart from DONE, never halt ----
      pulse_start();
      check_val("t2_done_clr", 64'(done),         64'd0);
      check_val("t2_cyc_clr",  64'(cycle_count),  64'd0);
      check_val("t2_wds_clr",  64'(words_loaded), 64'd0);
      check_val("t2_busy",     64'(busy),         64'd1);
      load_words(1, 1'b1, 32'h2000_0000);
      tick();
      tick();
      run_cycles(49, 0, 32'hB000_0000);
      check_val("t2_not_yet", 64'(done),        64'd0);
      check_val("t2_cyc49",   64'(cycle_count), 64'd49);
      cpu_data = 32'hB000_0032;
      tick();
      check_val("t2_done",    64'(done),        64'd1);
      check_val("t2_timeout", 64'(timeout),     64'd1);
      check_val("t2_cycles",  64'(cycle_count), 64'd50);
      check_val("t2_result",  64'(result),      64'hB000_0032);
      check_val("t2_crst",    64'(cpu_rst_n),   64'd0);

      // ---- truncation: 6 words, no last, 4-word memory ----
      pulse_start();
      check_val("t3_to_clr", 64'(timeout), 64'd0);
      for (int k = 0; k < 6; k++) begin
         load_valid = 1'b1;
         load_last  = 1'b0;
         load_data  = 32'h0000_00C0 + 32'(k);
         #1;
         check_val("t3_we",    64'(im_we),      64'(k < 4));
         check_val("t3_ready", 64'(load_ready), 64'(k < 4));
         if (k < 4) check_val("t3_addr", 64'(im_addr), 64'(k));
         tick();
      end
      load_valid = 1'b0;
      check_val("t3_trunc", 64'(load_trunc),   64'd1);
      check_val("t3_words", 64'(words_loaded), 64'd4);
      check_val("t3_run",   64'(cpu_rst_n),    64'd1);
      cpu_halt = 1'b1;
      cpu_data = 32'h3333_3333;
      tick();
      cpu_halt = 1'b0;
      check_val("t3_done",       64'(done),        64'd1);
      check_val("t3_trunc_hold", 64'(load_trunc),  64'd1);
      check_val("t3_cycles",     64'(cycle_count), 64'd1);

      // ---- stalls with a start pulse mid-load ----
      pulse_start();
      check_val("t4_trunc_clr", 64'(load_trunc), 64'd0);
      begin
         logic [4:0] vpat;
         int         nw;
         vpat = 5'b10101;
         nw   = 0;
         for (int c = 0; c < 5; c++) begin
            load_valid = vpat[c];
            load_last  = (c == 4);
            load_data  = 32'h4000_0000 + 32'(c);
            start      = (c == 1);
            #1;
            check_val("t4_we", 64'(im_we), 64'(vpat[c]));
            if (vpat[c]) check_val("t4_addr", 64'(im_addr), 64'(nw));
            tick();
            start = 1'b0;
            check_val("t4_busy", 64'(busy), 64'd1);
            if (vpat[c]) nw++;
         end
      end
      load_valid = 1'b0;
      load_last  = 1'b0;
      check_val("t4_words", 64'(words_loaded), 64'd3);
      tick();
      tick();
      cpu_halt = 1'b1;
      tick();
      cpu_halt = 1'b0;
      check_val("t4_done",   64'(done),        64'd1);
      check_val("t4_cycles", 64'(cycle_count), 64'd1);

      // ---- halt and budget on the same cycle ----
      pulse_start();
      load_words(1, 1'b1, 32'h5000_0000);
      tick();
      tick();
      run_cycles(50, 50, 32'h5500_0000);
      check_val("t5_done",    64'(done),        64'd1);
      check_val("t5_timeout", 64'(timeout),     64'd0);
      check_val("t5_cycles",  64'(cycle_count), 64'd50);
      check_val("t5_result",  64'(result),      64'h5500_0032);

      // ---- rst during a LOAD beat: no write in the rst cycle ----
      pulse_start();
      load_valid = 1'b1;
      load_data  = 32'h6000_0000;
      rst        = 1'b1;
      #1;
      check_val("t6_rst_we",    64'(im_we),      64'd0);
      check_val("t6_rst_ready", 64'(load_ready), 64'd0);
      tick();
      rst        = 1'b0;
      load_valid = 1'b0;
      check_val("t6_idle_busy", 64'(busy), 64'd0);

      // ---- rst on RUN cycle 5, then a clean rerun ----
      pulse_start();
      load_words(2, 1'b1, 32'h7000_0000);
      tick();
      tick();
      run_cycles(4, 0, 32'h7700_0000);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      check_val("t6_busy",    64'(busy),         64'd0);
      check_val("t6_done",    64'(done),         64'd0);
      check_val("t6_crst",    64'(cpu_rst_n),    64'd0);
      check_val("t6_cycles",  64'(cycle_count),  64'd0);
      check_val("t6_words",   64'(words_loaded), 64'd0);
      check_val("t6_result",  64'(result),       64'd0);
      check_val("t6_timeout", 64'(timeout),      64'd0);
      check_val("t6_trunc",   64'(load_trunc),   64'd0);
      check_val("t6_ready",   64'(load_ready),   64'd0);
      pulse_start();
      load_words(2, 1'b1, 32'h8000_0000);
      tick();
      tick();
      run_cycles(3, 3, 32'hD000_0000);
      check_val("t6r_done",    64'(done),         64'd1);
      check_val("t6r_cycles",  64'(cycle_count),  64'd3);
      check_val("t6r_result",  64'(result),       64'hD000_0003);
      check_val("t6r_timeout", 64'(timeout),      64'd0);
      check_val("t6r_words",   64'(words_loaded), 64'd2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
